// File: rtl/control_unit.sv
// Instruction sequencer for the simple processor frame.
// Fetches via IR load in T0, then decodes {opcode, Rx, Ry} over T1..T3 to drive
// register enables, the bus source select and the ALU controls.
module control_unit #(
  parameter int unsigned NREG  = 8,
  parameter int unsigned INS_W = 9
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iRun,
  input  logic [INS_W-1:0]  iIns,
  output logic [NREG-1:0]   oEn,
  output logic [NREG+1:0]   oMux,
  output logic [2:0]        oALU,
  output logic              oIR,
  output logic              oBusy,
  output logic              oDone
);

  // Bus select bit positions above the register sources.
  localparam int unsigned GoutSel  = NREG;
  localparam int unsigned DinSel   = NREG + 1;

  localparam logic [2:0] OpMv  = 3'b000;
  localparam logic [2:0] OpMvi = 3'b001;
  localparam logic [2:0] OpAdd = 3'b010;
  localparam logic [2:0] OpSub = 3'b011;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StT0   = 3'd1,
    StT1   = 3'd2,
    StT2   = 3'd3,
    StT3   = 3'd4
  } state_e;

  state_e state_q, state_d;

  logic [2:0] opc;
  logic [2:0] rx;
  logic [2:0] ry;

  assign opc = iIns[INS_W-1 -: 3];
  assign rx  = iIns[5:3];
  assign ry  = iIns[2:0];

  // State register; reset aborts any instruction in flight.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: a done slot chains straight into the next fetch when iRun is held.
  always_comb begin
    state_d = StIdle;
    unique case (state_q)
      StIdle: state_d = iRun ? StT0 : StIdle;
      StT0:   state_d = StT1;
      StT1: begin
        if (opc == OpAdd || opc == OpSub) begin
          state_d = StT2;
        end else begin
          state_d = iRun ? StT0 : StIdle;
        end
      end
      StT2:   state_d = StT3;
      StT3:   state_d = iRun ? StT0 : StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output decode from the current slot and the instruction fields.
  always_comb begin
    oEn   = '0;
    oMux  = '0;
    oALU  = 3'b000;
    oIR   = 1'b0;
    oBusy = 1'b0;
    oDone = 1'b0;
    unique case (state_q)
      StIdle: ;
      StT0: begin
        oBusy = 1'b1;
        oIR   = 1'b1;
      end
      StT1: begin
        oBusy = 1'b1;
        unique case (opc)
          OpMv: begin
            oMux[ry] = 1'b1;
            oEn[rx]  = 1'b1;
            oDone    = 1'b1;
          end
          OpMvi: begin
            oMux[DinSel] = 1'b1;
            oEn[rx]      = 1'b1;
            oDone        = 1'b1;
          end
          OpAdd, OpSub: begin
            oMux[rx] = 1'b1;
            oALU     = 3'b100;
          end
          // Undefined opcodes retire as a NOP.
          default: oDone = 1'b1;
        endcase
      end
      StT2: begin
        oBusy    = 1'b1;
        oMux[ry] = 1'b1;
        oALU     = {2'b01, opc[0]};
      end
      StT3: begin
        oBusy         = 1'b1;
        oMux[GoutSel] = 1'b1;
        oEn[rx]       = 1'b1;
        oDone         = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit with a small behavioural datapath frame
// (registers, A, G, IR, bus) so register results can be checked as well as controls.
module tb_control_unit;

  localparam int unsigned NREG  = 8;
  localparam int unsigned INS_W = 9;

  logic              clk;
  logic              rst;
  logic              run;
  logic [INS_W-1:0]  ins;
  logic [NREG-1:0]   en;
  logic [NREG+1:0]   mux;
  logic [2:0]        alu;
  logic              ir_ld;
  logic              busy;
  logic              done;

  logic [15:0] din;
  logic [15:0] bus;
  logic [15:0] r [NREG];
  logic [15:0] a_reg;
  logic [15:0] g_reg;
  logic [INS_W-1:0] ir;

  int n_tests = 0;
  int n_fail  = 0;

  control_unit #(
    .NREG  (NREG),
    .INS_W (INS_W)
  ) dut (
    .iClk  (clk),
    .iRst  (rst),
    .iRun  (run),
    .iIns  (ins),
    .oEn   (en),
    .oMux  (mux),
    .oALU  (alu),
    .oIR   (ir_ld),
    .oBusy (busy),
    .oDone (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign ins = ir;

  // Frame bus: DINout, Gout, then R7..R0.
  always_comb begin
    bus = '0;
    if (mux[NREG+1]) bus = din;
    else if (mux[NREG]) bus = g_reg;
    else begin
      for (int k = 0; k < NREG; k++) begin
        if (mux[k]) bus = r[k];
      end
    end
  end

  // Frame storage updated by the control outputs.
  always @(posedge clk) begin
    if (ir_ld) ir <= din[INS_W-1:0];
    for (int k = 0; k < NREG; k++) begin
      if (en[k]) r[k] <= bus;
    end
    if (alu[2]) a_reg <= bus;
    if (alu[1]) g_reg <= alu[0] ? (a_reg - bus) : (a_reg + bus);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Invariants checked every cycle outside reset.
  always @(negedge clk) begin
    if (!rst) begin
      check("mux_onehot0", 32'($countones(mux) <= 1), 32'd1);
      check("en_ir_excl", 32'((|en) && ir_ld), 32'd0);
    end
  end

  // Apply din/run for the next rising edge, then land on the following falling edge.
  task automatic step(input logic [15:0] d, input logic rn);
    din = d;
    run = rn;
    @(negedge clk);
  endtask

  function automatic logic [23:0] all_out();
    return {en, mux, alu, ir_ld, busy, done};
  endfunction

  task automatic do_mvi(input logic [2:0] rx, input logic [15:0] imm);
    step(16'd0, 1'b1);
    step({7'd0, 3'b001, rx, 3'b000}, 1'b0);
    step(imm, 1'b0);
  endtask

  logic [15:0] b2b_din [9];
  int done_cnt;
  int ir_cnt;
  int busy_cnt;

  initial begin
    rst = 1'b1;
    run = 1'b0;
    din = '0;
    ir  = '0;
    a_reg = '0;
    g_reg = '0;
    for (int k = 0; k < NREG; k++) r[k] = '0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("reset_outputs", 32'(all_out()), 32'd0);
    rst = 1'b0;
    step(16'd0, 1'b0);
    check("idle_outputs", 32'(all_out()), 32'd0);

    // mvi R0,35
    step(16'd0, 1'b1);
    check("mvi_t0_ir", 32'(ir_ld), 32'd1);
    check("mvi_t0_busy", 32'(busy), 32'd1);
    step(16'b001_000_000, 1'b0);
    check("mvi_t1_en", 32'(en), 32'h01);
    check("mvi_t1_mux", 32'(mux), 32'h200);
    check("mvi_t1_done", 32'(done), 32'd1);
    step(16'd35, 1'b0);
    check("mvi_r0", 32'(r[0]), 32'd35);
    check("mvi_idle_busy", 32'(busy), 32'd0);

    do_mvi(3'd3, 16'd954);
    do_mvi(3'd1, 16'd35);
    check("mvi_r3", 32'(r[3]), 32'd954);
    check("mvi_r1", 32'(r[1]), 32'd35);

    // mv R7,R3
    step(16'd0, 1'b1);
    step(16'b000_111_011, 1'b0);
    check("mv_t1_en", 32'(en), 32'h80);
    check("mv_t1_mux", 32'(mux), 32'h008);
    check("mv_t1_done", 32'(done), 32'd1);
    step(16'd0, 1'b0);
    check("mv_r7", 32'(r[7]), 32'd954);

    // add R3,R1
    step(16'd0, 1'b1);
    step(16'b010_011_001, 1'b0);
    check("add_t1_mux", 32'(mux), 32'h008);
    check("add_t1_alu", 32'(alu), 32'b100);
    check("add_t1_done", 32'(done), 32'd0);
    step(16'd0, 1'b0);
    check("add_t2_mux", 32'(mux), 32'h002);
    check("add_t2_alu", 32'(alu), 32'b010);
    step(16'd0, 1'b0);
    check("add_t3_en", 32'(en), 32'h08);
    check("add_t3_mux", 32'(mux), 32'h100);
    check("add_t3_done", 32'(done), 32'd1);
    step(16'd0, 1'b0);
    check("add_r3", 32'(r[3]), 32'd989);
    check("add_idle", 32'(all_out()), 32'd0);

    // sub R7,R0
    step(16'd0, 1'b1);
    step(16'b011_111_000, 1'b0);
    step(16'd0, 1'b0);
    check("sub_t2_mux", 32'(mux), 32'h001);
    check("sub_t2_alu", 32'(alu), 32'b011);
    step(16'd0, 1'b0);
    check("sub_t3_en", 32'(en), 32'h80);
    check("sub_t3_done", 32'(done), 32'd1);
    step(16'd0, 1'b0);
    check("sub_r7", 32'(r[7]), 32'd919);

    // Back-to-back: mvi R2,7 ; add R2,R2 ; NOP (opcode 110), iRun held high
    b2b_din = '{16'd0, 16'b001_010_000, 16'd7, 16'b010_010_010,
                16'd0, 16'd0, 16'd0, 16'b110_000_000, 16'd0};
    done_cnt = 0;
    ir_cnt   = 0;
    busy_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      step(b2b_din[i], 1'b1);
      if (done) done_cnt++;
      if (ir_ld) ir_cnt++;
      if (busy) busy_cnt++;
    end
    check("b2b_nop_done", 32'(done), 32'd1);
    check("b2b_nop_en", 32'(en), 32'd0);
    check("b2b_done_pulses", 32'(done_cnt), 32'd3);
    check("b2b_fetches", 32'(ir_cnt), 32'd3);
    check("b2b_busy_cycles", 32'(busy_cnt), 32'd8);
    check("b2b_r2_doubled", 32'(r[2]), 32'd14);
    step(b2b_din[8], 1'b0);
    check("b2b_exit_idle", 32'(all_out()), 32'd0);

    // Asynchronous reset mid-T2 of add R1,R0: no write to R1
    step(16'd0, 1'b1);
    step(16'b010_001_000, 1'b0);
    step(16'd0, 1'b0);
    check("rst_pre_t2_alu", 32'(alu), 32'b010);
    rst = 1'b1;
    #2;
    check("rst_async_outputs", 32'(all_out()), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    step(16'd0, 1'b0);
    step(16'd0, 1'b0);
    check("rst_release_idle", 32'(all_out()), 32'd0);
    check("rst_release_busy", 32'(busy), 32'd0);
    check("rst_no_write_r1", 32'(r[1]), 32'd35);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
